// File: rtl/anneal_sequencer.sv
// anneal_sequencer: broadcast command sequencer for the or_node array.
// Each iteration is a fixed schedule: random draw, delta-distance phase,
// metropolis test, replica exchange test, then the ordering shift window.
// All command outputs are registered; they are decoded from the next state
// so that each one is high exactly while the FSM sits in the matching state.
module anneal_sequencer #(
    parameter int city_num = 64,
    parameter int dist_cyc = 8,
    parameter int mtr_lat  = 4,
    parameter int rep_lat  = 4,
    parameter int iter_w   = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [iter_w-1:0] run_times,
    output logic              busy,
    output logic              done,
    output logic [iter_w-1:0] iter_cnt,
    output logic [1:0]        opt_command,
    output logic              random_run,
    output logic [1:0]        distance_com,
    output logic              metropolis_run,
    output logic              replica_run,
    output logic              exchange_run,
    output logic              exchange_shift_d,
    output logic              exchange_bank
);

    // FIN is the finishing cycle of NEXT: done is high there and start is ignored.
    typedef enum logic [3:0] {
        IDLE, RAND, DIST, MTR, MWAIT, REP, RWAIT, EXCH, SHIFT, NEXT, FIN
    } state_t;

    // One phase counter serves every multi-cycle state; size it for the longest.
    localparam int MAX_A   = (city_num > dist_cyc) ? city_num : dist_cyc;
    localparam int MAX_B   = (mtr_lat > rep_lat) ? mtr_lat : rep_lat;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] DIST_LAST  = CNT_W'(dist_cyc - 1);
    localparam logic [CNT_W-1:0] MTR_LAST   = CNT_W'(mtr_lat - 1);
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(rep_lat - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(city_num - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [1:0]        dcom_next;
    logic [iter_w-1:0] run_lat;
    logic [iter_w-1:0] iter_inc;

    assign iter_inc = iter_cnt + iter_w'(1);

    // Next-state, phase counter and delta-distance code for the coming cycle.
    always_comb begin
        next_state = state;
        cnt_next   = '0;
        dcom_next  = 2'd0;
        case (state)
            IDLE:  if (start) next_state = (run_times == '0) ? FIN : RAND;
            RAND:  next_state = DIST;
            DIST:  if (cnt == DIST_LAST) next_state = MTR;
            MTR:   next_state = MWAIT;
            MWAIT: if (cnt == MTR_LAST) next_state = REP;
            REP:   next_state = RWAIT;
            RWAIT: if (cnt == REP_LAST) next_state = EXCH;
            EXCH:  next_state = SHIFT;
            SHIFT: if (cnt == SHIFT_LAST) next_state = NEXT;
            NEXT:  next_state = ((iter_inc == run_lat) || abort) ? FIN : RAND;
            FIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // The counter restarts at zero on every state entry and runs while the state holds.
        if ((next_state == state) && (state != IDLE)) begin
            cnt_next = cnt + CNT_W'(1);
        end
        if (next_state == DIST) begin
            if (cnt_next == DIST_LAST) begin
                dcom_next = 2'd3;
            end else if (cnt_next == '0) begin
                dcom_next = 2'd1;
            end else begin
                dcom_next = 2'd2;
            end
        end
    end

    // State register and registered command outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            random_run       <= 1'b0;
            distance_com     <= 2'd0;
            metropolis_run   <= 1'b0;
            replica_run      <= 1'b0;
            exchange_run     <= 1'b0;
            exchange_shift_d <= 1'b0;
        end else begin
            state            <= next_state;
            cnt              <= cnt_next;
            busy             <= (next_state != IDLE) && (next_state != FIN);
            done             <= (next_state == FIN);
            random_run       <= (next_state == RAND);
            distance_com     <= dcom_next;
            metropolis_run   <= (next_state == MTR);
            replica_run      <= (next_state == REP);
            exchange_run     <= (next_state == EXCH);
            exchange_shift_d <= (next_state == SHIFT);
        end
    end

    // Run bookkeeping: latch the target on start, advance count and toggles in NEXT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_lat       <= '0;
            iter_cnt      <= '0;
            opt_command   <= 2'd0;
            exchange_bank <= 1'b0;
        end else if ((state == IDLE) && start) begin
            run_lat  <= run_times;
            iter_cnt <= '0;
        end else if (state == NEXT) begin
            iter_cnt      <= iter_inc;
            opt_command   <= {1'b0, ~opt_command[0]};
            exchange_bank <= ~exchange_bank;
        end
    end

endmodule

// File: doc/anneal_sequencer.md
Name: anneal_sequencer

Overview:
- Central command sequencer that sits directly upstream of every or_node.
- It issues one annealing iteration per loop as a fixed sequence: random draw, delta-distance calculation, metropolis test, replica exchange test, then ordering exchange.
- It drives the broadcast control inputs that all nodes share, counts iterations, and hands completion back to the host-facing controller.

Parameters:
- city_num, 64: number of cities; sets the length of the ordering shift window.
- dist_cyc, 8: cycles in the delta-distance phase (at least 2).
- mtr_lat, 4: wait cycles after the metropolis_run pulse before the replica test.
- rep_lat, 4: wait cycles after the replica_run pulse before exchange.
- iter_w, 24: width of the iteration counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- abort  in  1  level; stops the run at the next iteration boundary
- run_times  in  iter_w  number of iterations; sampled on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the run ends
- iter_cnt  out  iter_w  iterations completed in the current run
- opt_command  out  2  0=2-opt, 1=or-opt; toggles every iteration
- random_run  out  1  one-cycle pulse: draw K, L and randoms
- distance_com  out  2  0=nop, 1=first, 2=mid, 3=last delta-distance cycle
- metropolis_run  out  1  one-cycle pulse
- replica_run  out  1  one-cycle pulse
- exchange_run  out  1  one-cycle pulse
- exchange_shift_d  out  1  high for city_num cycles after exchange_run
- exchange_bank  out  1  ordering bank select; toggles at the end of each iteration

Behaviour:
- Reset clears all outputs and returns the FSM to IDLE. iter_cnt=0, opt_command=0, exchange_bank=0.
- Reset is legal mid-run: every pulse output drops immediately and no done pulse is issued.
- FSM states: IDLE, RAND, DIST, MTR, MWAIT, REP, RWAIT, EXCH, SHIFT, NEXT.
- IDLE:
  - On start, latch run_times, clear iter_cnt, set busy.
  - Go to RAND, or to NEXT-done if run_times=0.
  - start while busy is ignored.
- RAND: random_run=1 for one cycle, then DIST.
- DIST: runs dist_cyc cycles using a phase counter.
  - distance_com is 1 on the first cycle, 3 on the last cycle, 2 in between.
  - Then MTR.
- MTR: metropolis_run=1 for one cycle. MWAIT holds for mtr_lat cycles.
- REP: replica_run=1 for one cycle. RWAIT holds for rep_lat cycles.
- EXCH: exchange_run=1 for one cycle.
- SHIFT: exchange_shift_d=1 for exactly city_num cycles, starting the cycle after exchange_run.
- NEXT (one cycle):
  - iter_cnt += 1; exchange_bank and opt_command toggle.
  - If iter_cnt+1 == latched run_times, or abort=1: done=1 and busy=0 in the next cycle, then IDLE.
  - Otherwise go to RAND.
- opt_command is stable for the whole iteration and changes only in NEXT.
- Iteration length is fixed: L = 1 + dist_cyc + 1 + mtr_lat + 1 + rep_lat + 1 + city_num + 1 cycles. With defaults, L = 85.
- Pulse outputs are registered and mutually exclusive; at most one of the run pulses is high in any cycle.
- abort is sampled only in NEXT. An abort that falls between NEXT states is lost if it deasserts before the next NEXT.
- Wrap: run_times is compared with equality, so iter_cnt never exceeds run_times. run_times = 2^iter_w-1 is legal.
- Simultaneous start and abort in IDLE: start wins. abort is then evaluated at the first NEXT, giving exactly 1 iteration.
- done and start in the same cycle: start is ignored, because done is asserted while still in the finishing state. A new start is accepted from IDLE on the following cycle.

Test Plan:
- Single iteration:
  - Stimulus: reset, then start with run_times=1.
  - Response: random_run at cycle 1; distance_com sequence 1,2,2,2,2,2,2,3; metropolis_run at 10; replica_run at 15; exchange_run at 20; exchange_shift_d high for cycles 21–84.
  - Then done at 86, iter_cnt=1, exchange_bank=1, opt_command=1.
- Multi-run:
  - Stimulus: run_times=4.
  - Response: four random_run pulses spaced 85 cycles apart; opt_command sequence 0,1,0,1; final exchange_bank=0; done once.
- Zero length:
  - Stimulus: run_times=0.
  - Response: no run pulses; done within 3 cycles; iter_cnt=0.
- Abort:
  - Stimulus: run_times=100, abort raised during iteration 3.
  - Response: iteration 3 completes fully; done at its NEXT; iter_cnt=3.
- Reset mid-operation:
  - Stimulus: assert reset during SHIFT.
  - Response: exchange_shift_d=0 and busy=0 immediately; no done pulse.
  - A following start runs normally from iter_cnt=0.
- Start while busy:
  - Stimulus: a second start pulse mid-run with run_times=2.
  - Response: ignored; the run still ends after 2 iterations.
